ro_puf_meas_ctrl: RTL

- Sequences the ring-oscillator PUF datapath for one challenge.
- For each response bit, it:
  - selects an RO pair,
  - enables the oscillators for a settle time,
  - counts edges over a fixed measurement window,
  - compares the two counts and shifts the result bit into a response word.
- Sits between the AXI4-Lite register slave (start, challenge, nbits, abort in; status and response out) and the RO array and its edge synchronizers.

---
 rtl/ro_puf_meas_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ro_puf_meas_ctrl.sv
// ro_puf_meas_ctrl
// Measurement sequencer for a ring-oscillator PUF. For each response bit it
// selects an RO pair and enables the oscillators. It waits a settle time,
// then counts synchronized edges of both oscillators over a fixed window.
// Finally it compares the two counts and stores the result bit in the
// response word.
//
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   start              : one-cycle request, accepted only when idle
//   abort              : stops any measurement in progress, no done pulse
//   challenge          : base RO index; bit i uses challenge+2i / +2i+1
//   nbits              : number of response bits (0 or >RESP_W means RESP_W)
//   ro_a_pulse/_b_pulse: one-cycle pulse per rising edge of RO A / RO B
//   ro_en              : oscillator enable (settle and measure phases)
//   ro_sel_a/ro_sel_b  : RO pair select for the current bit
//   busy               : high from the first settle cycle through the last compare
//   done               : one-cycle completion pulse
//   response           : result word, bit i = (count A > count B)
//   tie                : sticky, some compare saw equal counts
//   sat                : sticky, some edge counter tried to pass its maximum
module ro_puf_meas_ctrl #(
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8,
  parameter int RESP_W = 32,
  parameter int NB_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  challenge,
  input  logic [NB_W-1:0]   nbits,
  input  logic              ro_a_pulse,
  input  logic              ro_b_pulse,
  output logic              ro_en,
  output logic [SEL_W-1:0]  ro_sel_a,
  output logic [SEL_W-1:0]  ro_sel_b,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] response,
  output logic              tie,
  output logic              sat
);

  localparam int PH_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int IDX_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [PH_W-1:0]   phase;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic [NB_W-1:0]   eff_n;
  logic              accept, abort_run, settle_end, window_end, last_bit;

  assign accept     = (state == S_IDLE) && start && !abort;
  assign abort_run  = abort && (state != S_IDLE);
  assign settle_end = (phase == PH_W'(SETTLE - 1));
  assign window_end = (phase == PH_W'(WINDOW - 1));
  assign last_bit   = (bit_idx == last_idx);

  // A bit count of zero, or one larger than the word, means a full word.
  assign eff_n = ((nbits == '0) || (nbits > NB_W'(RESP_W))) ? NB_W'(RESP_W) : nbits;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    ro_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE:    if (accept) state_d = S_SETTLE;
      S_SETTLE: begin
        ro_en = 1'b1;
        busy  = 1'b1;
        if (settle_end) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        ro_en = 1'b1;
        busy  = 1'b1;
        if (window_end) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        busy    = 1'b1;
        state_d = last_bit ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
    // Abort beats every transition, including DONE -> IDLE.
    if (abort_run) state_d = S_IDLE;
  end

  // The selects are registered, so they stay stable for a whole bit. They
  // move on by two only when a compare hands over to the next bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase    <= '0;
      bit_idx  <= '0;
      last_idx <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      ro_sel_a <= '0;
      ro_sel_b <= '0;
      response <= '0;
      tie      <= 1'b0;
      sat      <= 1'b0;
    end else if (accept) begin
      phase    <= '0;
      bit_idx  <= '0;
      last_idx <= IDX_W'(eff_n - NB_W'(1));
      cnt_a    <= '0;
      cnt_b    <= '0;
      ro_sel_a <= challenge;
      ro_sel_b <= challenge + SEL_W'(1);
      response <= '0;
      tie      <= 1'b0;
      sat      <= 1'b0;
    end else if (abort_run) begin
      // Partial response, tie and sat are kept for software to inspect.
      phase <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      case (state)
        S_SETTLE: phase <= settle_end ? '0 : phase + PH_W'(1);
        S_MEASURE: begin
          phase <= window_end ? '0 : phase + PH_W'(1);
          if (ro_a_pulse) begin
            if (cnt_a == '1) sat <= 1'b1;
            else             cnt_a <= cnt_a + CNT_W'(1);
          end
          if (ro_b_pulse) begin
            if (cnt_b == '1) sat <= 1'b1;
            else             cnt_b <= cnt_b + CNT_W'(1);
          end
        end
        S_COMPARE: begin
          response[bit_idx] <= (cnt_a > cnt_b);
          if (cnt_a == cnt_b) tie <= 1'b1;
          cnt_a <= '0;
          cnt_b <= '0;
          phase <= '0;
          if (!last_bit) begin
            bit_idx  <= bit_idx + IDX_W'(1);
            ro_sel_a <= ro_sel_a + SEL_W'(2);
            ro_sel_b <= ro_sel_b + SEL_W'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
